// File: rtl/inert_spi_resp.sv
`default_nettype none
// ============================================================================
// Module : inert_spi_resp
// Brief  : SPI mode-0 responder standing in for the inertial sensor; serves a
//          small register map and raises INT on each new pitch/roll/yaw sample.
// Rev    : 1.0  initial release
// ============================================================================
module inert_spi_resp #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter logic [6:0] INT_CLR_ADDR = 7'h27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  output logic [7:0]  int_cfg,
  output logic        wr_vld,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [6:0] ADDR_INT_CFG = 7'h0D;
  localparam logic [6:0] ADDR_WHO     = 7'h0F;
  localparam logic [4:0] CNT_CMD      = 5'd8;
  localparam logic [4:0] CNT_FRAME    = 5'd16;
  localparam logic [4:0] CNT_MAX      = 5'd31;

  logic [2:0]  ss_sync_q, ss_sync_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  int_cfg_q, int_cfg_d;
  logic        wr_vld_q, wr_vld_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [47:0] data_q, data_d;
  logic [47:0] hold_q, hold_d;
  logic        pend_q, pend_d;
  logic        upd_q, upd_d;
  logic        int_q, int_d;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  logic        commit, wr_commit, rd_clr;
  logic [7:0]  rd_data;

  assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
  assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  always_comb begin
    ss_sync_d   = {ss_sync_q[1:0], SS_n};
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
  end

  // Register map, indexed by the command byte held in rx at the end of CMD
  always_comb begin
    rd_data = 8'h00;
    case (rx_q[6:0])
      ADDR_INT_CFG: rd_data = int_cfg_q;
      ADDR_WHO:     rd_data = WHO_AM_I_VAL;
      7'h22:        rd_data = data_q[7:0];
      7'h23:        rd_data = data_q[15:8];
      7'h24:        rd_data = data_q[23:16];
      7'h25:        rd_data = data_q[31:24];
      7'h26:        rd_data = data_q[39:32];
      7'h27:        rd_data = data_q[47:40];
      default:      rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = CMD;
          rx_d      = 8'h00;
          tx_d      = 8'h00;
          bit_cnt_d = 5'd0;
        end
      end
      CMD: begin
        if (bit_cnt_q == CNT_CMD) begin
          rw_d    = rx_q[7];
          addr_d  = rx_q[6:0];
          tx_d    = rx_q[7] ? rd_data : 8'h00;
          state_d = DATA;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      DATA: begin
        if (sclk_rise) begin
          rx_d = {rx_q[6:0], mosi_s};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        // The fall right after the 8th rise must keep bit 7 on MISO for the 9th rise
        if (sclk_fall && (bit_cnt_q != CNT_CMD)) tx_d = {tx_q[6:0], 1'b0};
      end
      default: state_d = IDLE;
    endcase
    if (ss_rise && (state_q != IDLE)) begin
      state_d = IDLE;
      commit  = (state_q == DATA) && (bit_cnt_q == CNT_FRAME);
    end
  end

  assign wr_commit = commit & ~rw_q;
  assign rd_clr    = commit & rw_q & (addr_q == INT_CLR_ADDR);

  always_comb begin
    wr_vld_d  = wr_commit;
    wr_addr_d = wr_commit ? addr_q : wr_addr_q;
    wr_data_d = wr_commit ? rx_q : wr_data_q;
    int_cfg_d = (wr_commit && (addr_q == ADDR_INT_CFG)) ? rx_q : int_cfg_q;
  end

  // Samples arriving mid-frame are parked so a loaded read byte never changes
  always_comb begin
    data_d = data_q;
    hold_d = hold_q;
    pend_d = pend_q;
    upd_d  = 1'b0;
    if (state_q == IDLE) begin
      if (smpl_vld) begin
        data_d = {yaw, roll, ptch};
        upd_d  = 1'b1;
        pend_d = 1'b0;
      end else if (pend_q) begin
        data_d = hold_q;
        upd_d  = 1'b1;
        pend_d = 1'b0;
      end
    end else if (smpl_vld) begin
      hold_d = {yaw, roll, ptch};
      pend_d = 1'b1;
    end
    int_d = int_q;
    if (rd_clr) int_d = 1'b0;
    if (upd_q && int_cfg_q[1]) int_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 7'h00;
      int_cfg_q   <= 8'h00;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= 7'h00;
      wr_data_q   <= 8'h00;
      data_q      <= 48'h0;
      hold_q      <= 48'h0;
      pend_q      <= 1'b0;
      upd_q       <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      int_cfg_q   <= int_cfg_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      data_q      <= data_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      upd_q       <= upd_d;
      int_q       <= int_d;
    end
  end

  assign MISO    = (state_q == DATA) & tx_q[7];
  assign INT     = int_q;
  assign int_cfg = int_cfg_q;
  assign wr_vld  = wr_vld_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_inert_spi_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_inert_spi_resp
// Brief  : Directed plus randomized frames for inert_spi_resp against a
//          register-level model of the sensor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inert_spi_resp;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] ptch = 16'h0, roll = 16'h0, yaw = 16'h0;
  logic        MISO, INT, wr_vld;
  logic [7:0]  int_cfg, wr_data;
  logic [6:0]  wr_addr;

  inert_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .smpl_vld(smpl_vld), .ptch(ptch), .roll(roll),
    .yaw(yaw), .int_cfg(int_cfg), .wr_vld(wr_vld), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_hi = 0;
  int exp_wr = 0;

  always @(negedge clk) if (wr_vld === 1'b1) wr_hi <= wr_hi + 1;

  // Sensor model: register contents as seen from the SPI side
  logic [7:0]  m_int_cfg;
  logic [7:0]  m_regs [6];
  logic        m_int;
  logic [6:0]  m_wr_addr;
  logic [7:0]  m_wr_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'h0D) return m_int_cfg;
    if (a == 7'h0F) return 8'h6A;
    if (a >= 7'h22 && a <= 7'h27) return m_regs[int'(a) - 34];
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_int_cfg = 8'h00;
    m_int     = 1'b0;
    m_wr_addr = 7'h00;
    m_wr_data = 8'h00;
    for (int k = 0; k < 6; k++) m_regs[k] = 8'h00;
  endtask

  task automatic m_sample(input logic [47:0] s);
    for (int k = 0; k < 6; k++) m_regs[k] = s[8*k +: 8];
    if (m_int_cfg[1]) m_int = 1'b1;
  endtask

  // s = {yaw, roll, ptch}
  task automatic strobe(input logic [47:0] s);
    @(negedge clk);
    ptch = s[15:0]; roll = s[31:16]; yaw = s[47:32];
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, input int at1, input int at2,
                           input logic [47:0] s1, input logic [47:0] s2, output logic [7:0] rdb);
    rdb = 8'h00;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      if (i >= 8 && i < 16) rdb = {rdb[6:0], MISO};
      if (i == at1) strobe(s1);
      if (i == at2) strobe(s2);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_frame(input logic [15:0] word, input int nbits, input int at1, input int at2,
                          input logic [47:0] s1, input logic [47:0] s2);
    logic [7:0] rdb;
    logic [7:0] exp_rd;
    logic       rw;
    logic [6:0] a;
    rw = word[15];
    a  = word[14:8];
    exp_rd = m_read(a);
    spi_frame(word, nbits, at1, at2, s1, s2, rdb);
    if (nbits == 16) begin
      if (rw) begin
        check_val($sformatf("rd_%02h", a), 32'(rdb), 32'(exp_rd));
        if (a == 7'h27) m_int = 1'b0;
      end else begin
        exp_wr++;
        m_wr_addr = a;
        m_wr_data = word[7:0];
        if (a == 7'h0D) m_int_cfg = word[7:0];
      end
    end
    if (at2 >= 0 && at2 < nbits) m_sample(s2);
    else if (at1 >= 0 && at1 < nbits) m_sample(s1);
    check_val("wr_vld_cycles", 32'(wr_hi), 32'(exp_wr));
    check_val("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
    check_val("wr_data", 32'(wr_data), 32'(m_wr_data));
    check_val("int_cfg", 32'(int_cfg), 32'(m_int_cfg));
    check_val("INT", 32'(INT), 32'(m_int));
    check_val("miso_idle", 32'(MISO), 32'd0);
  endtask

  task automatic idle_sample(input logic [47:0] s);
    strobe(s);
    repeat (6) @(negedge clk);
    m_sample(s);
    check_val("INT_after_smpl", 32'(INT), 32'(m_int));
  endtask

  function automatic logic [6:0] pick_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r < 6) return 7'(7'h22 + r);
    if (r == 6) return 7'h0D;
    if (r == 7) return 7'h0F;
    return 7'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] s1, s2;
    logic [15:0] w;
    int op, nb, a1, a2;

    m_reset();
    repeat (3) @(negedge clk);
    check_val("rst_MISO", 32'(MISO), 32'd0);
    check_val("rst_INT", 32'(INT), 32'd0);
    check_val("rst_int_cfg", 32'(int_cfg), 32'd0);
    check_val("rst_wr_vld", 32'(wr_vld), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_frame(16'h8F00, 16, -1, -1, 48'h0, 48'h0);
    do_frame(16'h0D02, 16, -1, -1, 48'h0, 48'h0);
    idle_sample({16'h1234, 16'h5678, 16'h9ABC});
    do_frame(16'hA600, 16, -1, -1, 48'h0, 48'h0);
    do_frame(16'hA700, 16, -1, -1, 48'h0, 48'h0);
    do_frame(16'hA400, 16, 10, -1, {16'h1111, 16'hABCD, 16'h2222}, 48'h0);
    do_frame(16'hA400, 16, -1, -1, 48'h0, 48'h0);
    do_frame(16'h0D00, 12, -1, -1, 48'h0, 48'h0);
    do_frame(16'h8F00, 16, -1, -1, 48'h0, 48'h0);

    // Reset during the data phase of a WHO_AM_I read
    w = 16'h8F00;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      MOSI = w[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < 9) SCLK = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst_MISO", 32'(MISO), 32'd0);
    check_val("midrst_INT", 32'(INT), 32'd0);
    check_val("midrst_int_cfg", 32'(int_cfg), 32'd0);
    SS_n = 1'b1;
    SCLK = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    do_frame(16'h8F00, 16, -1, -1, 48'h0, 48'h0);

    for (int it = 0; it < 140; it++) begin
      op = $urandom_range(0, 7);
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      a1 = -1;
      a2 = -1;
      nb = 16;
      if (op <= 2) begin
        w = {1'b1, pick_addr(), 8'($urandom)};
      end else if (op <= 4) begin
        w = {1'b0, ($urandom_range(0, 1) == 1) ? 7'h0D : 7'($urandom), 8'($urandom)};
      end else if (op == 5) begin
        idle_sample(s1);
        continue;
      end else if (op == 6) begin
        w  = {1'($urandom_range(0, 1)), pick_addr(), 8'($urandom)};
        nb = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 19) : $urandom_range(1, 15);
      end else begin
        w = {1'b1, pick_addr(), 8'($urandom)};
      end
      if (op == 7 || $urandom_range(0, 3) == 0) begin
        a1 = $urandom_range(0, nb - 1);
        if ($urandom_range(0, 1) == 1 && a1 < nb - 1) a2 = $urandom_range(a1 + 1, nb - 1);
      end
      do_frame(w, nb, a1, a2, s1, s2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
